// File: rtl/matrix_bank_pkg.sv
// Shared definitions for the matrix storage bank: default geometry, depth
// helper and the load FSM state encoding.
package matrix_bank_pkg;

  localparam int DEF_MAX_WIDTH_LEN = 3;
  localparam int DEF_SIZE_VALUE    = 16;
  localparam int MAT_DEPTH         = 1 << (2 * DEF_MAX_WIDTH_LEN);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  function automatic int mat_depth(input int width_len);
    return 1 << (2 * width_len);
  endfunction

endpackage

// File: rtl/matrix_bank_ram.sv
// Single-write / single-read synchronous RAM with a registered read port;
// a read of the address being written returns the previous contents.
module matrix_bank_ram
  import matrix_bank_pkg::*;
#(
  parameter int ADDR_W = 2 * DEF_MAX_WIDTH_LEN,
  parameter int DATA_W = DEF_SIZE_VALUE,
  parameter int DEPTH  = MAT_DEPTH
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0]        raddr,
  output logic signed [DATA_W-1:0] rdata
);

  logic signed [DATA_W-1:0] mem [DEPTH];
  logic signed [DATA_W-1:0] rd_data_d;
  logic signed [DATA_W-1:0] rd_data_q;

  always_comb begin
    rd_data_d = mem[raddr];
  end

  // Read register samples the array before this edge's write lands.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = rd_data_q;

endmodule

// File: rtl/matrix_bank.sv
// Holds matrices A and B: two masked coordinate read ports with one-cycle
// latency plus a row-major valid/ready load stream for either matrix.
module matrix_bank
  import matrix_bank_pkg::*;
#(
  parameter int MAX_WIDTH_LEN = DEF_MAX_WIDTH_LEN,
  parameter int SIZE_VALUE    = DEF_SIZE_VALUE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [MAX_WIDTH_LEN-1:0]     rx1,
  input  logic [MAX_WIDTH_LEN-1:0]     ry1,
  output logic signed [SIZE_VALUE-1:0] out1,
  input  logic [MAX_WIDTH_LEN-1:0]     rx2,
  input  logic [MAX_WIDTH_LEN-1:0]     ry2,
  output logic signed [SIZE_VALUE-1:0] out2,
  input  logic                         load_start,
  input  logic                         load_sel,
  input  logic [MAX_WIDTH_LEN-1:0]     load_w,
  input  logic [MAX_WIDTH_LEN-1:0]     load_h,
  input  logic                         in_valid,
  input  logic signed [SIZE_VALUE-1:0] in_data,
  output logic                         in_ready,
  output logic                         load_done,
  output logic [MAX_WIDTH_LEN-1:0]     width1,
  output logic [MAX_WIDTH_LEN-1:0]     height1,
  output logic [MAX_WIDTH_LEN-1:0]     width2,
  output logic [MAX_WIDTH_LEN-1:0]     height2,
  output logic                         valid1,
  output logic                         valid2
);

  localparam int ADDR_W = 2 * MAX_WIDTH_LEN;
  localparam int DEPTH  = mat_depth(MAX_WIDTH_LEN);

  load_state_e state_q, state_d;
  logic                     sel_q, sel_d;
  logic [MAX_WIDTH_LEN-1:0] w_q, w_d, h_q, h_d;
  logic [MAX_WIDTH_LEN-1:0] x_q, x_d, y_q, y_d;
  logic                     valid1_q, valid1_d, valid2_q, valid2_d;
  logic [MAX_WIDTH_LEN-1:0] width1_q, width1_d, height1_q, height1_d;
  logic [MAX_WIDTH_LEN-1:0] width2_q, width2_d, height2_q, height2_d;
  logic                     rd_ok1_q, rd_ok1_d, rd_ok2_q, rd_ok2_d;

  logic                         we_a, we_b;
  logic [ADDR_W-1:0]            waddr;
  logic signed [SIZE_VALUE-1:0] ram_a_rd, ram_b_rd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      sel_q     <= 1'b0;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      valid1_q  <= 1'b0;
      valid2_q  <= 1'b0;
      width1_q  <= '0;
      height1_q <= '0;
      width2_q  <= '0;
      height2_q <= '0;
      rd_ok1_q  <= 1'b0;
      rd_ok2_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      valid1_q  <= valid1_d;
      valid2_q  <= valid2_d;
      width1_q  <= width1_d;
      height1_q <= height1_d;
      width2_q  <= width2_d;
      height2_q <= height2_d;
      rd_ok1_q  <= rd_ok1_d;
      rd_ok2_q  <= rd_ok2_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    valid1_d  = valid1_q;
    valid2_d  = valid2_q;
    width1_d  = width1_q;
    height1_d = height1_q;
    width2_d  = width2_q;
    height2_d = height2_q;
    in_ready  = 1'b0;
    load_done = 1'b0;
    we_a      = 1'b0;
    we_b      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          sel_d   = load_sel;
          w_d     = load_w;
          h_d     = load_h;
          x_d     = '0;
          y_d     = '0;
          // Hide the target immediately so half-written data never reads back.
          if (load_sel) begin
            valid2_d = 1'b0;
          end else begin
            valid1_d = 1'b0;
          end
        end
      end
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          we_a = ~sel_q;
          we_b = sel_q;
          if (x_q == w_q) begin
            x_d = '0;
            if (y_q == h_q) begin
              y_d     = '0;
              state_d = ST_DONE;
            end else begin
              y_d = y_q + 1'b1;
            end
          end else begin
            x_d = x_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        load_done = 1'b1;
        state_d   = ST_IDLE;
        if (sel_q) begin
          valid2_d  = 1'b1;
          width2_d  = w_q;
          height2_d = h_q;
        end else begin
          valid1_d  = 1'b1;
          width1_d  = w_q;
          height1_d = h_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Mask decision travels alongside the RAM read so it lines up at the output.
    rd_ok1_d = valid1_q && (rx1 <= width1_q) && (ry1 <= height1_q);
    rd_ok2_d = valid2_q && (rx2 <= width2_q) && (ry2 <= height2_q);
  end

  assign waddr = {y_q, x_q};

  matrix_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (SIZE_VALUE),
    .DEPTH  (DEPTH)
  ) u_ram_a (
    .clk   (clk),
    .we    (we_a),
    .waddr (waddr),
    .wdata (in_data),
    .raddr ({ry1, rx1}),
    .rdata (ram_a_rd)
  );

  matrix_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (SIZE_VALUE),
    .DEPTH  (DEPTH)
  ) u_ram_b (
    .clk   (clk),
    .we    (we_b),
    .waddr (waddr),
    .wdata (in_data),
    .raddr ({ry2, rx2}),
    .rdata (ram_b_rd)
  );

  assign out1    = rd_ok1_q ? ram_a_rd : '0;
  assign out2    = rd_ok2_q ? ram_b_rd : '0;
  assign width1  = width1_q;
  assign height1 = height1_q;
  assign width2  = width2_q;
  assign height2 = height2_q;
  assign valid1  = valid1_q;
  assign valid2  = valid2_q;

endmodule

// File: tb/tb_matrix_bank.sv
// Self-checking bench for matrix_bank: random loads and reads compared
// against an array model of the two matrices.
module tb_matrix_bank;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         rx1, ry1, rx2, ry2;
  logic signed [15:0] out1, out2;
  logic               load_start, load_sel;
  logic [2:0]         load_w, load_h;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic               in_ready, load_done;
  logic [2:0]         width1, height1, width2, height2;
  logic               valid1, valid2;

  int checks = 0;
  int errors = 0;

  // Model: flat 8x8 arrays indexed y*8+x, plus published state per matrix.
  logic signed [15:0] ref_mem [2][64];
  logic               ref_vld [2];
  logic [2:0]         ref_w [2];
  logic [2:0]         ref_h [2];
  logic signed [15:0] beat [64];
  logic signed [15:0] exp1, exp2;

  matrix_bank dut (
    .clk(clk), .rst(rst),
    .rx1(rx1), .ry1(ry1), .out1(out1),
    .rx2(rx2), .ry2(ry2), .out2(out2),
    .load_start(load_start), .load_sel(load_sel), .load_w(load_w), .load_h(load_h),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .load_done(load_done),
    .width1(width1), .height1(height1), .width2(width2), .height2(height2),
    .valid1(valid1), .valid2(valid2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] model_rd(input int m, input int x, input int y);
    if (!ref_vld[m] || x > int'(ref_w[m]) || y > int'(ref_h[m])) return 16'sd0;
    return ref_mem[m][y * 8 + x];
  endfunction

  task automatic rd(input int x1, input int y1, input int x2, input int y2);
    rx1 = x1[2:0]; ry1 = y1[2:0]; rx2 = x2[2:0]; ry2 = y2[2:0];
    exp1 = model_rd(0, x1, y1);
    exp2 = model_rd(1, x2, y2);
    @(posedge clk); @(negedge clk);
  endtask

  // Streams beat[0..n-1] into matrix sel; random reads on both ports each beat.
  task automatic do_load(input int sel, input int w, input int h, input int gap,
                         input int spur, input int abort);
    int n;
    int x1, y1, x2, y2;
    logic signed [15:0] e1, e2;
    n = (w + 1) * (h + 1);
    load_start = 1'b1; load_sel = sel[0]; load_w = w[2:0]; load_h = h[2:0];
    @(posedge clk); ref_vld[sel] = 1'b0; @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == abort) begin
        in_valid = 1'b0;
        rst = 1'b1;
        ref_vld[0] = 1'b0; ref_vld[1] = 1'b0;
        ref_w[0] = 3'd0; ref_h[0] = 3'd0; ref_w[1] = 3'd0; ref_h[1] = 3'd0;
        return;
      end
      if (i == spur) begin
        in_valid = 1'b0;
        load_start = 1'b1; load_sel = ~sel[0]; load_w = 3'd0; load_h = 3'd0;
        @(posedge clk); @(negedge clk);
        load_start = 1'b0;
      end
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
      end
      in_valid = 1'b1; in_data = beat[i];
      x1 = $urandom_range(7); y1 = $urandom_range(7);
      x2 = $urandom_range(7); y2 = $urandom_range(7);
      rx1 = x1[2:0]; ry1 = y1[2:0]; rx2 = x2[2:0]; ry2 = y2[2:0];
      e1 = model_rd(0, x1, y1); e2 = model_rd(1, x2, y2);
      checks++;
      if (in_ready !== 1'b1 || load_done !== 1'b0) begin
        errors++;
        $display("FAIL load_handshake beat %0d: in_ready=%b load_done=%b want 1/0", i, in_ready, load_done);
      end
      @(posedge clk);
      ref_mem[sel][(i / (w + 1)) * 8 + (i % (w + 1))] = beat[i];
      @(negedge clk);
      checks++;
      if (out1 !== e1 || out2 !== e2) begin
        errors++;
        $display("FAIL load_reads beat %0d: out1=%0d out2=%0d want %0d %0d", i, out1, out2, e1, e2);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (load_done !== 1'b1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_done_pulse: load_done=%b in_ready=%b want 1/0", load_done, in_ready);
    end
    @(posedge clk);
    ref_vld[sel] = 1'b1; ref_w[sel] = w[2:0]; ref_h[sel] = h[2:0];
    @(negedge clk);
    checks++;
    if (load_done !== 1'b0) begin
      errors++;
      $display("FAIL load_done_width: load_done=%b want 0", load_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load_start = 1'b0; load_sel = 1'b0; load_w = 3'd0; load_h = 3'd0;
    in_valid = 1'b0; in_data = 16'sd0;
    for (int m = 0; m < 2; m++) begin
      ref_vld[m] = 1'b0; ref_w[m] = 3'd0; ref_h[m] = 3'd0;
    end
    rd(0, 0, 2, 3);
    rd(0, 0, 2, 3);
    checks++;
    if (out1 !== 16'sd0 || out2 !== 16'sd0) begin
      errors++;
      $display("FAIL reset_out: out1=%0d out2=%0d want 0 0", out1, out2);
    end
    checks++;
    if (valid1 !== 1'b0 || valid2 !== 1'b0 || in_ready !== 1'b0 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: v1=%b v2=%b rdy=%b done=%b want 0000", valid1, valid2, in_ready, load_done);
    end
    checks++;
    if ({width1, height1, width2, height2} !== 12'd0) begin
      errors++;
      $display("FAIL reset_dims: %0d %0d %0d %0d want 0", width1, height1, width2, height2);
    end
    rst = 1'b0;
    rd(0, 0, 2, 3);
    checks++;
    if (out1 !== exp1 || out2 !== exp2) begin
      errors++;
      $display("FAIL reset_read: out1=%0d out2=%0d want %0d %0d", out1, out2, exp1, exp2);
    end
  endtask

  task automatic test_load_a();
    beat[0] = 16'sd1; beat[1] = 16'sd2; beat[2] = 16'sd3; beat[3] = 16'sd4;
    do_load(0, 1, 1, 0, -1, -1);
    checks++;
    if (valid1 !== 1'b1 || width1 !== 3'd1 || height1 !== 3'd1) begin
      errors++;
      $display("FAIL load_a_dims: v=%b w=%0d h=%0d want 1 1 1", valid1, width1, height1);
    end
    rd(1, 0, 0, 0);
    checks++;
    if (out1 !== 16'sd2) begin
      errors++;
      $display("FAIL load_a_read10: got %0d want 2", out1);
    end
    rd(0, 1, 0, 0);
    checks++;
    if (out1 !== 16'sd3 || out2 !== exp2) begin
      errors++;
      $display("FAIL load_a_read01: out1=%0d out2=%0d want 3 %0d", out1, out2, exp2);
    end
  endtask

  task automatic test_load_b_gaps();
    beat[0] = -16'sd5; beat[1] = 16'sd7; beat[2] = 16'sd9;
    do_load(1, 2, 0, 3, -1, -1);
    checks++;
    if (valid2 !== 1'b1 || width2 !== 3'd2 || height2 !== 3'd0) begin
      errors++;
      $display("FAIL load_b_dims: v=%b w=%0d h=%0d want 1 2 0", valid2, width2, height2);
    end
    rd(1, 1, 2, 0);
    checks++;
    if (out2 !== 16'sd9 || out1 !== 16'sd4) begin
      errors++;
      $display("FAIL load_b_read20: out2=%0d out1=%0d want 9 4", out2, out1);
    end
    rd(0, 0, 0, 1);
    checks++;
    if (out2 !== 16'sd0 || out1 !== 16'sd1) begin
      errors++;
      $display("FAIL load_b_oob: out2=%0d out1=%0d want 0 1", out2, out1);
    end
    rd(0, 0, 0, 0);
    checks++;
    if (out2 !== -16'sd5) begin
      errors++;
      $display("FAIL load_b_neg: got %0d want -5", out2);
    end
  endtask

  task automatic test_ignored_start();
    for (int i = 0; i < 4; i++) beat[i] = 16'($urandom);
    do_load(1, 1, 1, 1, 2, -1);
    checks++;
    if (valid1 !== 1'b1 || width1 !== 3'd1 || height1 !== 3'd1 || valid2 !== 1'b1 || width2 !== 3'd1) begin
      errors++;
      $display("FAIL ignored_start_flags: v1=%b w1=%0d h1=%0d v2=%b w2=%0d want 1 1 1 1 1",
               valid1, width1, height1, valid2, width2);
    end
    for (int i = 0; i < 4; i++) begin
      rd(i % 2, i / 2, i % 2, i / 2);
      checks++;
      if (out1 !== exp1 || out2 !== exp2) begin
        errors++;
        $display("FAIL ignored_start_read %0d: out1=%0d out2=%0d want %0d %0d", i, out1, out2, exp1, exp2);
      end
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 64; i++) beat[i] = 16'(i);
    do_load(0, 7, 7, 0, -1, -1);
    for (int i = 0; i < 64; i++) begin
      rd(i % 8, i / 8, $urandom_range(7), $urandom_range(7));
      checks++;
      if (out1 !== 16'(i) || out2 !== exp2) begin
        errors++;
        $display("FAIL full_read %0d: out1=%0d out2=%0d want %0d %0d", i, out1, out2, i, exp2);
      end
    end
    // Reload A; the per-beat reads cover A[2][5] while it is rewritten.
    for (int i = 0; i < 64; i++) beat[i] = 16'(100 + i);
    do_load(0, 7, 7, 0, -1, -1);
    rd(5, 2, 0, 0);
    checks++;
    if (out1 !== 16'sd121) begin
      errors++;
      $display("FAIL full_rewrite: got %0d want 121", out1);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int t = 0; t < 6; t++) begin
      int sel, w, h;
      sel = $urandom_range(1);
      w = $urandom_range(7);
      h = $urandom_range(7);
      for (int i = 0; i < 64; i++) beat[i] = 16'($urandom);
      do_load(sel, w, h, $urandom_range(2), -1, -1);
      checks++;
      if (valid1 !== ref_vld[0] || valid2 !== ref_vld[1] || width1 !== ref_w[0] || height1 !== ref_h[0]
          || width2 !== ref_w[1] || height2 !== ref_h[1]) begin
        errors++;
        $display("FAIL random_dims %0d: v=%b%b a=%0dx%0d b=%0dx%0d want v=%b%b a=%0dx%0d b=%0dx%0d", t,
                 valid1, valid2, width1, height1, width2, height2,
                 ref_vld[0], ref_vld[1], ref_w[0], ref_h[0], ref_w[1], ref_h[1]);
      end
      for (int k = 0; k < 20; k++) begin
        rd($urandom_range(7), $urandom_range(7), $urandom_range(7), $urandom_range(7));
        checks++;
        if (out1 !== exp1 || out2 !== exp2) begin
          errors++;
          $display("FAIL random_read %0d/%0d: out1=%0d out2=%0d want %0d %0d", t, k, out1, out2, exp1, exp2);
        end
      end
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 9; i++) beat[i] = 16'($urandom);
    do_load(0, 2, 2, 0, -1, 5);
    #1;
    checks++;
    if (out1 !== 16'sd0 || out2 !== 16'sd0 || in_ready !== 1'b0 || load_done !== 1'b0
        || valid1 !== 1'b0 || valid2 !== 1'b0) begin
      errors++;
      $display("FAIL midload_reset: out1=%0d out2=%0d rdy=%b done=%b v=%b%b want all 0",
               out1, out2, in_ready, load_done, valid1, valid2);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || {width1, height1, width2, height2} !== 12'd0) begin
      errors++;
      $display("FAIL midload_idle: rdy=%b dims=%0d %0d %0d %0d want 0", in_ready, width1, height1, width2, height2);
    end
    for (int k = 0; k < 6; k++) begin
      rd($urandom_range(2), $urandom_range(2), $urandom_range(7), $urandom_range(7));
      checks++;
      if (out1 !== 16'sd0 || out2 !== 16'sd0) begin
        errors++;
        $display("FAIL midload_read %0d: out1=%0d out2=%0d want 0 0", k, out1, out2);
      end
    end
    for (int i = 0; i < 9; i++) beat[i] = 16'($urandom);
    do_load(0, 2, 2, 0, -1, -1);
    for (int i = 0; i < 9; i++) begin
      rd(i % 3, i / 3, 0, 0);
      checks++;
      if (out1 !== beat[i] || out2 !== 16'sd0) begin
        errors++;
        $display("FAIL midload_recover %0d: out1=%0d out2=%0d want %0d 0", i, out1, out2, beat[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_a();
    test_load_b_gaps();
    test_ignored_start();
    test_full();
    test_back_to_back_random();
    test_reset_midload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
